axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns a valid/ready command stream into AXI-Lite write or read transactions.
- Returns each result on a valid/ready response stream.
- Sits between PS-side/debug command logic and the existing AXI-Lite slave register bank.
- A per-transaction watchdog halts the block and flags a fault if the slave never answers.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (multiple of 8).
- TIMEOUT, 1000, max cycles from command acceptance to B/R handshake (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  response produced by watchdog
- timed_out  out  1  sticky fault flag
- m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI4-Lite master ports, widths per ADDR_W/DATA_W
- Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: state IDLE; all *valid/*ready outputs 0; rsp_* data 0; timed_out 0; watchdog 0. cmd_ready rises the first cycle after rst deasserts.
- awprot/arprot tied 3'b000; wstrb all ones.
- States: IDLE, WRITE, WRESP, READ, RDATA, RESPOND, HALT.
- IDLE: cmd_ready=1. On cmd handshake (cycle N), register addr/wdata/write. Go to WRITE or READ; AXI valids assert in cycle N+1.
- WRITE: awvalid and wvalid are independent. Each drops the cycle after its own handshake. Same-cycle AW and W acceptance is legal. When both are done, go to WRESP.
- WRESP: bready=1. On bvalid, latch bresp and go to RESPOND.
- READ: arvalid=1 until arready, then RDATA.
- RDATA: rready=1. On rvalid, latch rdata/rresp and go to RESPOND.
- RESPOND: rsp_valid=1, rsp_* fields stable. On rsp_ready, go to IDLE. cmd_ready stays 0 until IDLE, so back-to-back throughput is at most one command per 4 cycles.
- Latency, zero-wait slave: cmd handshake N -> AXI valid N+1 -> B/R handshake N+2 -> rsp_valid N+3.
- Watchdog:
  - Clears on cmd handshake and increments every cycle in WRITE/WRESP/READ/RDATA.
  - If it reaches TIMEOUT-1 before the B/R handshake: deassert all AXI valids/readys next cycle, load rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0, set timed_out, enter RESPOND.
  - After that response is consumed, enter HALT.
  - A B/R handshake in the same cycle the count hits TIMEOUT-1 wins: normal response, no timeout.
- HALT: cmd_ready=0, bready=rready=0, all AXI valids 0. Only rst exits.
- Watchdog does not run in RESPOND; rsp backpressure is unbounded.
- Reset mid-transaction aborts immediately: outputs return to reset values asynchronously and no response is issued.
- SLVERR/DECERR from the slave is passed through in rsp_resp with rsp_timeout=0 and does not halt.

Test Plan:
- Zero-wait slave, write 0xDEADBEEF to 0x10 then read 0x10 -> rsp 1: write=1, resp=0. rsp 2: rdata=0xDEADBEEF, resp=0. Each rsp_valid 3 cycles after its cmd handshake.
- Slave holds awready 0 for 5 cycles while wready=1 immediately -> wvalid drops after 1 cycle, awvalid held 6 cycles, one B handshake, single response.
- rsp_ready held 0 for 20 cycles -> rsp_valid and fields stable, cmd_ready=0, timed_out stays 0 with TIMEOUT=16.
- TIMEOUT=16, slave never asserts rvalid -> 15 cycles after cmd handshake all AXI valids drop; rsp_resp=2'b10, rsp_timeout=1, timed_out=1; a further cmd_valid is never accepted until rst.
- Slave returns RRESP=2'b11 -> rsp_resp=2'b11, rsp_timeout=0, next command accepted normally.
- Assert rst during WRESP -> bready/rsp_valid/cmd_ready 0 immediately, no response after release, next write completes normally.

Source files
------------

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI-Lite transaction out,
// one response back. A per-transaction watchdog turns a silent slave into a sticky fault.
module axil_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst,
  // command stream
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  // response stream
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                timed_out,
  // AXI4-Lite write address
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  // AXI4-Lite write data
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  // AXI4-Lite read address
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  // AXI4-Lite read data
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  // debug: current FSM state
  output logic [2:0]          fsm_state
);

  // Handshake rule on every stream: a beat transfers on a rising clk edge where
  // valid and ready are both high; valid never depends combinationally on ready.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WRESP   = 3'd2,
    READ    = 3'd3,
    RDATA   = 3'd4,
    RESPOND = 3'd5,
    HALT    = 3'd6
  } state_t;

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The last busy cycle in which a B/R handshake is still honoured; the
  // watchdog register reaches TIMEOUT-1 at the edge that ends it.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

  state_t              state, state_next;
  logic                active;
  logic [WD_W-1:0]     wd;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q;
  logic                aw_done, w_done;
  logic                rsp_write_q, rsp_timeout_q, timed_out_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;

  logic cmd_fire, aw_fire, w_fire, b_fire, r_fire;
  logic busy, xfer, expire;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign aw_fire  = m_axi_awvalid & m_axi_awready;
  assign w_fire   = m_axi_wvalid & m_axi_wready;
  assign b_fire   = m_axi_bvalid & m_axi_bready;
  assign r_fire   = m_axi_rvalid & m_axi_rready;

  assign busy   = (state == WRITE) || (state == WRESP) ||
                  (state == READ)  || (state == RDATA);
  assign xfer   = b_fire | r_fire;
  assign expire = busy & ~xfer & (wd == WD_LAST);

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = '1;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;
  assign timed_out   = timed_out_q;
  assign fsm_state   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        // active holds cmd_ready low for the first cycle out of reset
        cmd_ready = active;
        if (cmd_valid && active) state_next = cmd_write ? WRITE : READ;
      end
      WRITE: begin
        m_axi_awvalid = ~aw_done;
        m_axi_wvalid  = ~w_done;
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_next = WRESP;
      end
      WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = RESPOND;
      end
      READ: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = RDATA;
      end
      RDATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_next = RESPOND;
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = rsp_timeout_q ? HALT : IDLE;
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
    if (expire) state_next = RESPOND;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active        <= 1'b0;
      wd            <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      timed_out_q   <= 1'b0;
    end else begin
      active <= 1'b1;
      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        write_q <= cmd_write;
        wd      <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (busy) begin
        wd <= wd + WD_W'(1);
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      // watchdog expiry and a real B/R handshake are mutually exclusive by construction
      if (expire) begin
        rsp_write_q   <= write_q;
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= 2'b10;
        rsp_timeout_q <= 1'b1;
        timed_out_q   <= 1'b1;
      end else if (b_fire) begin
        rsp_write_q   <= 1'b1;
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= m_axi_bresp;
        rsp_timeout_q <= 1'b0;
      end else if (r_fire) begin
        rsp_write_q   <= 1'b0;
        rsp_rdata_q   <= m_axi_rdata;
        rsp_resp_q    <= m_axi_rresp;
        rsp_timeout_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a delay-programmable AXI-Lite memory slave, a command
// driver, and a scoreboard fed by a transaction-level model of memory and latency.
module tb_axil_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HALT = 3'd6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_timeout, timed_out;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot, fsm_state;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  axil_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .timed_out(timed_out),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .fsm_state(fsm_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0] slv_resp;
  logic [DW-1:0] slv_mem [logic [AW-1:0]];
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_seen, w_seen, ar_seen, b_go, r_go;
  logic [AW-1:0] aw_addr_s, ar_addr_s;
  logic [DW-1:0] w_data_s;
  logic [DW/8-1:0] w_strb_s;
  int aw_cyc, w_cyc, ar_cyc, b_hs;

  task automatic slave_clear();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; b_go = 0; r_go = 0;
  endtask

  task automatic set_slave(input int a, input int w, input int b, input int ar, input int r,
                           input logic [1:0] resp);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r; slv_resp = resp;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_clear();
        continue;
      end
      if (awvalid) aw_cyc++;
      if (wvalid)  w_cyc++;
      if (arvalid) ar_cyc++;
      // B channel is evaluated before AW/W so a fresh address/data beat waits a cycle
      if (b_go) begin
        bvalid = 0; b_go = 0; b_hs++;
        if (bresp == 2'b00) slv_mem[aw_addr_s] = w_data_s;
        aw_seen = 0; w_seen = 0; b_cnt = 0;
      end else if (bvalid) begin
        b_go = bready;
      end else if (aw_seen && w_seen) begin
        if (b_cnt >= b_dly) begin
          bvalid = 1; bresp = slv_resp; b_go = bready;
        end else b_cnt++;
      end
      if (awvalid) begin
        if (aw_cnt >= aw_dly) begin awready = 1; aw_seen = 1; aw_addr_s = awaddr; end
        else begin awready = 0; aw_cnt++; end
      end else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin
        if (w_cnt >= w_dly) begin wready = 1; w_seen = 1; w_data_s = wdata; w_strb_s = wstrb; end
        else begin wready = 0; w_cnt++; end
      end else begin wready = 0; w_cnt = 0; end
      if (r_go) begin
        rvalid = 0; r_go = 0; ar_seen = 0; r_cnt = 0;
      end else if (rvalid) begin
        r_go = rready;
      end else if (ar_seen) begin
        if (r_cnt >= r_dly) begin
          rvalid = 1; rresp = slv_resp;
          rdata = slv_mem.exists(ar_addr_s) ? slv_mem[ar_addr_s] : '0;
          r_go = rready;
        end else r_cnt++;
      end
      if (arvalid) begin
        if (ar_cnt >= ar_dly) begin arready = 1; ar_seen = 1; ar_addr_s = araddr; end
        else begin arready = 0; ar_cnt++; end
      end else begin arready = 0; ar_cnt = 0; end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // expected entry: {write, rdata, resp, timeout}
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW+3:0] exp_q[$];

  function automatic logic [DW+3:0] predict(input bit wr, input logic [AW-1:0] a,
                                            input logic [DW-1:0] d, input logic [1:0] resp);
    if (wr) begin
      if (resp == 2'b00) model_mem[a] = d;
      return {1'b1, {DW{1'b0}}, resp, 1'b0};
    end
    return {1'b0, model_mem[a], resp, 1'b0};
  endfunction

  // Cycles from command handshake to rsp_valid for a slave with the given delays.
  function automatic int model_latency(input bit wr);
    if (wr) return 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
    return 3 + ar_dly + r_dly;
  endfunction

  task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int hs_cyc, output bit ok);
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    ok = 0;
    hs_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    hs_cyc = cyc;
    if (ok) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 0;
  endtask

  task automatic get_rsp(input int hold, input int exp_lat, input int hs_cyc);
    logic [DW+3:0] e;
    int t;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    check("rsp_valid_seen", rsp_valid, 1'b1);
    if (!rsp_valid) return;
    if (exp_lat >= 0) check("rsp_latency", cyc - hs_cyc, exp_lat);
    if (exp_q.size() == 0) begin
      check("unexpected_rsp", 1'b1, 1'b0);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_fields", {rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout}, {1'b1, e});
      check("hold_cmd_ready", cmd_ready, 1'b0);
      check("hold_timed_out", timed_out, e[0]);
      @(negedge clk);
    end
    rsp_ready = 1;
    check("rsp_fields", {rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout}, {1'b1, e});
    check("timed_out", timed_out, e[0]);
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask

  // one full normal transaction through the model
  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    int hs;
    bit ok;
    int lat;
    lat = model_latency(wr);
    exp_q.push_back(predict(wr, a, d, slv_resp));
    send_cmd(wr, a, d, hs, ok);
    check("cmd_accept", ok, 1'b1);
    if (ok) get_rsp(hold, lat, hs);
    else void'(exp_q.pop_back());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  int hs, n_rsp;
  bit ok;

  initial begin
    rst = 1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0; b_hs = 0;
    set_slave(0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      slv_mem[AW'(i * 4)] = v;
      model_mem[AW'(i * 4)] = v;
    end
    repeat (3) @(negedge clk);
    check("rst_handshakes", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 7'b0);
    check("rst_rsp_data", {rsp_write, rsp_rdata, rsp_resp, rsp_timeout, timed_out}, 0);
    check("rst_state", fsm_state, ST_IDLE);
    check("rst_prot_strb", {awprot, arprot, wstrb}, {6'b0, 4'hF});
    rst = 0;
    #1 check("cmd_ready_at_release", cmd_ready, 1'b0);
    @(negedge clk);
    check("cmd_ready_after_release", cmd_ready, 1'b1);

    // zero-wait write then read-back
    set_slave(0, 0, 0, 0, 0, 2'b00);
    run_txn(1, 32'h10, 32'hDEADBEEF, 0);
    run_txn(0, 32'h10, 32'h0, 0);
    check("wstrb_seen", w_strb_s, 4'hF);

    // AW stalled five cycles, W accepted at once
    set_slave(5, 0, 0, 0, 0, 2'b00);
    aw_cyc = 0; w_cyc = 0; b_hs = 0;
    run_txn(1, 32'h4, 32'h12345678, 0);
    check("awvalid_cycles", aw_cyc, 6);
    check("wvalid_cycles", w_cyc, 1);
    check("b_handshakes", b_hs, 1);

    // long response backpressure
    set_slave(0, 0, 0, 0, 0, 2'b00);
    run_txn(0, 32'h4, 32'h0, 20);

    // slave error responses pass through without halting
    set_slave(0, 0, 0, 0, 0, 2'b11);
    run_txn(0, 32'h8, 32'h0, 0);
    set_slave(0, 0, 0, 0, 0, 2'b10);
    run_txn(1, 32'h8, 32'hA5A5A5A5, 1);
    set_slave(0, 0, 0, 0, 0, 2'b00);
    run_txn(0, 32'h8, 32'h0, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [1:0] rsp_code;
      rsp_code = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), rsp_code);
      run_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7) * 4), $urandom,
              $urandom_range(0, 3));
    end

    // watchdog boundary: R handshake in the last honoured cycle wins
    set_slave(0, 0, 0, 0, TO - 3, 2'b00);
    run_txn(0, 32'h0, 32'h0, 0);
    check("boundary_no_fault", timed_out, 1'b0);

    // one cycle later the watchdog fires
    set_slave(0, 0, 0, 0, TO - 2, 2'b00);
    exp_q.push_back({1'b0, {DW{1'b0}}, 2'b10, 1'b1});
    send_cmd(0, 32'h0, 32'h0, hs, ok);
    check("cmd_accept_r_late", ok, 1'b1);
    get_rsp(2, TO, hs);
    do_reset();
    check("timed_out_cleared", timed_out, 1'b0);

    // slave never accepts AR: valid held for TO-1 cycles, then halt
    set_slave(0, 0, 0, 1000, 0, 2'b00);
    ar_cyc = 0;
    exp_q.push_back({1'b0, {DW{1'b0}}, 2'b10, 1'b1});
    send_cmd(0, 32'h1C, 32'h0, hs, ok);
    check("cmd_accept_ar_hang", ok, 1'b1);
    get_rsp(0, TO, hs);
    check("arvalid_cycles", ar_cyc, TO - 1);
    @(negedge clk);
    check("halt_state", fsm_state, ST_HALT);
    check("halt_timed_out", timed_out, 1'b1);
    send_cmd(1, 32'h0, 32'h1, hs, ok);
    check("halt_cmd_blocked", ok, 1'b0);
    check("halt_handshakes", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 7'b0);
    do_reset();
    @(negedge clk);
    check("cmd_ready_after_halt_reset", cmd_ready, 1'b1);

    // reset while waiting in WRESP aborts without a response
    set_slave(0, 0, 8, 0, 0, 2'b00);
    send_cmd(1, 32'h14, 32'hCAFEF00D, hs, ok);
    check("cmd_accept_abort", ok, 1'b1);
    for (int i = 0; i < 20 && !bready; i++) @(negedge clk);
    check("reached_wresp", bready, 1'b1);
    #2 rst = 1;
    #1 check("abort_outputs", {bready, rsp_valid, cmd_ready}, 3'b000);
    check("abort_state", fsm_state, ST_IDLE);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    n_rsp = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    check("no_rsp_after_abort", n_rsp, 0);
    set_slave(0, 0, 0, 0, 0, 2'b00);
    run_txn(1, 32'h18, 32'h0BADF00D, 0);
    run_txn(0, 32'h14, 32'h0, 0);
    run_txn(0, 32'h18, 32'h0, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
